// File: rtl/bram_sync_sp_pipe.sv
// Single-port synchronous RAM with byte-enable writes and a post-reset / clr clear sweep.
// Latency: read or write response appears RD_LATENCY cycles after acceptance; fully pipelined.
// Backpressure: ready is low during the clear sweep; en while not ready is ignored.
module bram_sync_sp_pipe #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 4,
  parameter int                    RD_LATENCY     = 1,
  parameter int                    WRITE_MODE     = 0,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    wr,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    clr,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    valid,
  output logic                    ready
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   rd_word, merged, resp_dat;
  logic                    acc, resp_vld;
  logic [RD_LATENCY-1:0]   vld_pipe;
  logic [DATA_WIDTH-1:0]   dat_pipe [RD_LATENCY];

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CLEAR_ON_RESET ? CLEAR : RUN;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   state_nxt = clr ? CLEAR : ((&cnt) ? RUN : CLEAR);
      RUN:     state_nxt = clr ? CLEAR : RUN;
      default: state_nxt = CLEAR;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ready = (state == RUN);
  end

  // Sweep counter wraps back to 0 as the last address is written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (clr)            cnt <= '0;
    else if (state == CLEAR) cnt <= cnt + 1'b1;
  end

  assign acc     = en & ready;
  assign rd_word = mem[addr];

  always_comb begin
    merged = rd_word;
    for (int i = 0; i < NB; i++)
      if (be[i]) merged[8*i +: 8] = data_in[8*i +: 8];
  end

  assign resp_vld = acc & (~wr | (WRITE_MODE != 2));
  assign resp_dat = (wr && WRITE_MODE == 1) ? merged : rd_word;

  // Memory array is deliberately not reset
  always_ff @(posedge clk) begin
    if (state == CLEAR)  mem[cnt]  <= INIT_VALUE;
    else if (acc && wr)  mem[addr] <= merged;
  end

  // Data stages only move with a valid, so data_out holds between responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int i = 0; i < RD_LATENCY; i++) dat_pipe[i] <= '0;
    end else if (clr) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= resp_vld;
      if (resp_vld) dat_pipe[0] <= resp_dat;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign valid    = vld_pipe[RD_LATENCY-1];
  assign data_out = dat_pipe[RD_LATENCY-1];

endmodule

// File: doc/bram_sync_sp_pipe.md
BRAM_SYNC_SP_PIPE -- requirements
Module: bram_sync_sp_pipe

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning word width in bits; it SHALL be a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4, meaning address width; depth is 2**ADDR_WIDTH words.
REQ-003 The block SHALL have parameter RD_LATENCY, default 1, meaning cycles from accepted access to valid; legal range 1..4.
REQ-004 The block SHALL have parameter WRITE_MODE, default 0, meaning 0=READ_FIRST, 1=WRITE_FIRST, 2=NO_CHANGE.
REQ-005 The block SHALL have parameter CLEAR_ON_RESET, default 1, meaning the memory is swept to INIT_VALUE after reset.
REQ-006 The block SHALL have parameter INIT_VALUE, default 0, DATA_WIDTH bits, meaning the value written by a clear sweep.
REQ-007 Port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-008 Port rst_n, input, 1, meaning the asynchronous active-low reset.
REQ-009 Port en, input, 1, meaning an access request this cycle.
REQ-010 Port wr, input, 1, meaning the access is a write (1) or a read (0).
REQ-011 Port be, input, DATA_WIDTH/8, meaning byte enables for writes; be[i] covers data bits 8i+7:8i.
REQ-012 Port addr, input, ADDR_WIDTH, meaning the word address.
REQ-013 Port data_in, input, DATA_WIDTH, meaning the write data.
REQ-014 Port clr, input, 1, meaning a single-cycle request to start a clear sweep.
REQ-015 Port data_out, output, DATA_WIDTH, meaning registered read data.
REQ-016 Port valid, output, 1, meaning data_out carries the result of an access this cycle.
REQ-017 Port ready, output, 1, meaning accesses are accepted this cycle.

Function
REQ-018 The FSM SHALL have states CLEAR and RUN; ready SHALL be 1 only in RUN.
REQ-019 In CLEAR, a counter SHALL write INIT_VALUE to address 0, 1, ... 2**ADDR_WIDTH-1, one per cycle; after the last address is written the FSM SHALL enter RUN on the next edge (sweep = 2**ADDR_WIDTH cycles).
REQ-020 clr=1 in RUN SHALL enter CLEAR with counter 0; clr=1 in CLEAR SHALL restart the counter at 0.
REQ-021 clr=1 SHALL clear all in-flight valid bits; data_out SHALL hold its value.
REQ-022 An access SHALL be accepted iff en=1 and ready=1; en while ready=0 SHALL have no effect and produce no valid.
REQ-023 An accepted read SHALL produce valid=1 with data_out=mem[addr] exactly RD_LATENCY cycles after acceptance.
REQ-024 An accepted write SHALL update only the bytes with be[i]=1; be=0 SHALL leave memory unchanged but still count as an access.
REQ-025 Write response in READ_FIRST: valid after RD_LATENCY cycles, with data_out = word before the write.
REQ-026 Write response in WRITE_FIRST: valid after RD_LATENCY cycles, with data_out = merged word after the write.
REQ-027 Write response in NO_CHANGE: no valid; data_out holds.
REQ-028 A read accepted the cycle after a write to the same address SHALL return the written data.
REQ-029 Back-to-back accesses SHALL be accepted every cycle in RUN (throughput 1 per cycle, fully pipelined).
REQ-030 data_out SHALL hold its last value whenever valid=0.
REQ-031 Address wrap: addr is taken modulo depth; there is no out-of-range condition.

Reset
REQ-032 rst_n=0 SHALL asynchronously set: data_out=0, valid=0, all pipeline stages invalid, counter=0.
REQ-033 rst_n=0 SHALL set the FSM to CLEAR if CLEAR_ON_RESET=1, else to RUN.
REQ-034 Memory contents SHALL NOT be reset by rst_n; they are undefined after reset when CLEAR_ON_RESET=0.
REQ-035 Reset asserted mid-sweep or mid-pipeline SHALL abort the sweep and discard in-flight results; with CLEAR_ON_RESET=1 the sweep SHALL restart from address 0 after release.

Verification
REQ-036 Defaults, release reset: ready=0 for 16 cycles then 1; a read of every address returns 0x00000000, with valid 1 cycle after each read.
REQ-037 RD_LATENCY=3: write 0xDEADBEEF to addr 5, then read addr 5 on the next cycle -> valid and 0xDEADBEEF exactly 3 cycles after the read; a continuous read stream yields valid every cycle.
REQ-038 mem[2]=0x11223344, then write be=4'b0101 with data_in 0xAABBCCDD -> mem[2]=0x11BB33DD; READ_FIRST returns 0x11223344; WRITE_FIRST returns 0x11BB33DD; NO_CHANGE gives no valid.
REQ-039 clr pulsed while 2 reads are in flight -> no valid for either read; ready=0 for 16 cycles; a subsequent read of a prior non-zero address returns INIT_VALUE.
REQ-040 rst_n asserted mid-sweep at counter 7 -> valid=0 and data_out=0 immediately; after release, ready stays 0 for a full 16 cycles; en pulses during the sweep produce no valid.
